// File: rtl/lms_iter_ctrl.sv
// ---------------------------------------------------------------------------
// lms_iter_ctrl
// Sequencer for one LMS adaptive-filter iteration built around a single
// shared signed multiplier. Each accepted sample runs a TAPS-cycle filter
// pass, a one-cycle error computation and, unless frozen, a TAPS-cycle
// weight update, then offers y/e on an output handshake.
// The block owns the tap delay line and the weight registers.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   in_valid   sample offered             in_ready  sample accepted (IDLE)
//   x_in       signed input sample        d_in      signed desired response
//   freeze     skip weight update for the iteration accepted with it set
//   out_valid  y_out/e_out valid (DONE)   out_ready consumer takes result
//   y_out      saturated filter output    e_out     saturated error d - y
//   busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module lms_iter_ctrl #(
   parameter int TAPS     = 4,
   parameter int DW       = 8,
   parameter int FRAC     = 6,
   parameter int MU_SHIFT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] x_in,
   input  logic signed [DW-1:0] d_in,
   input  logic                 freeze,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] y_out,
   output logic signed [DW-1:0] e_out,
   output logic                 busy
);

   localparam int KW = $clog2(TAPS);
   // Full-precision accumulator: TAPS products of 2*DW bits never overflow.
   localparam int AW = 2*DW + $clog2(TAPS);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FILTER = 3'd1;
   localparam logic [2:0] S_ERROR  = 3'd2;
   localparam logic [2:0] S_UPDATE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
   localparam logic [KW-1:0]        K_LAST  = KW'(TAPS-1);

   logic [2:0]                 state_q, state_d;
   logic [KW-1:0]              k_q, k_d;
   logic signed [AW-1:0]       acc_q, acc_d;
   logic signed [DW-1:0]       x_q [TAPS];
   logic signed [DW-1:0]       x_d [TAPS];
   logic signed [DW-1:0]       w_q [TAPS];
   logic signed [DW-1:0]       w_d [TAPS];
   logic signed [DW-1:0]       d_q, d_d;
   logic signed [DW-1:0]       y_q, y_d;
   logic signed [DW-1:0]       e_q, e_d;
   logic                       freeze_q, freeze_d;

   logic signed [DW-1:0]       w_cur, x_cur;
   logic signed [2*DW-1:0]     prod_filt, prod_err, delta;
   logic signed [AW-1:0]       acc_shift;
   logic signed [DW-1:0]       y_calc, e_calc, w_new;

   // Clamp an AW-wide signed value into the DW-bit signed range.
   function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
      logic signed [DW-1:0] r;
      if (v > SAT_MAX)      r = SAT_MAX[DW-1:0];
      else if (v < SAT_MIN) r = SAT_MIN[DW-1:0];
      else                  r = v[DW-1:0];
      return r;
   endfunction

   function automatic logic signed [AW-1:0] sext_dw(input logic signed [DW-1:0] v);
      return {{(AW-DW){v[DW-1]}}, v};
   endfunction

   function automatic logic signed [AW-1:0] sext_p(input logic signed [2*DW-1:0] v);
      return {{(AW-2*DW){v[2*DW-1]}}, v};
   endfunction

   // Datapath around the shared multiplier. Operands are sign-extended to
   // 2*DW bits first; the low 2*DW bits of the product are exact because
   // the true product always fits in that width.
   always_comb begin
      w_cur     = w_q[k_q];
      x_cur     = x_q[k_q];
      prod_filt = $signed({{DW{w_cur[DW-1]}}, w_cur} * {{DW{x_cur[DW-1]}}, x_cur});
      prod_err  = $signed({{DW{e_q[DW-1]}}, e_q} * {{DW{x_cur[DW-1]}}, x_cur});
      // Arithmetic shifts give floor rounding, including for negative values.
      delta     = prod_err >>> MU_SHIFT;
      acc_shift = acc_q >>> FRAC;
      y_calc    = sat_dw(acc_shift);
      e_calc    = sat_dw(sext_dw(d_q) - sext_dw(y_calc));
      w_new     = sat_dw(sext_dw(w_cur) + sext_p(delta));
   end

   // Next-state logic for the iteration sequencer. Every register holds by
   // default; each state only overrides what it actually changes.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      acc_d    = acc_q;
      x_d      = x_q;
      w_d      = w_q;
      d_d      = d_q;
      y_d      = y_q;
      e_d      = e_q;
      freeze_d = freeze_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d[0] = x_in;
               for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
               d_d      = d_in;
               freeze_d = freeze;
               acc_d    = '0;
               k_d      = '0;
               state_d  = S_FILTER;
            end
         end
         S_FILTER: begin
            acc_d = acc_q + sext_p(prod_filt);
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = S_ERROR;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_ERROR: begin
            y_d     = y_calc;
            e_d     = e_calc;
            k_d     = '0;
            state_d = freeze_q ? S_DONE : S_UPDATE;
         end
         S_UPDATE: begin
            w_d[k_q] = w_new;
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = S_DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers. Reset wins in every state, so an in-flight iteration
   // is abandoned and the learned weights return to zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         acc_q    <= '0;
         d_q      <= '0;
         y_q      <= '0;
         e_q      <= '0;
         freeze_q <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            w_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         d_q      <= d_d;
         y_q      <= y_d;
         e_q      <= e_d;
         freeze_q <= freeze_d;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= x_d[i];
            w_q[i] <= w_d[i];
         end
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign y_out     = y_q;
   assign e_out     = e_q;

endmodule

// File: tb/tb_lms_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lms_iter_ctrl
// Scoreboard bench for lms_iter_ctrl (TAPS=4, DW=8, FRAC=6, MU_SHIFT=8).
// A behavioural LMS model predicts y/e and the acceptance-to-out_valid
// latency for every accepted sample and queues them; results are popped
// and compared when the controller raises out_valid.
// ---------------------------------------------------------------------------
module tb_lms_iter_ctrl;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] x_in;
   logic signed [7:0] d_in;
   logic              freeze;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] y_out;
   logic signed [7:0] e_out;
   logic              busy;

   typedef struct {
      int y;
      int e;
      int lat;
   } exp_t;

   exp_t sbQ[$];
   int   xm[4];
   int   wm[4];
   int   vectors     = 0;
   int   miscompares = 0;

   lms_iter_ctrl #(.TAPS(4), .DW(8), .FRAC(6), .MU_SHIFT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .d_in      (d_in),
      .freeze    (freeze),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_out     (y_out),
      .e_out     (e_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Absolute time limit so a stuck handshake can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int sat8(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 4; i++) begin
         xm[i] = 0;
         wm[i] = 0;
      end
   endfunction

   // Reference LMS iteration; pushes the expected result onto the scoreboard.
   function automatic void modelAccept(input int x, input int d, input bit frz);
      int   acc;
      exp_t ex;
      for (int i = 3; i > 0; i--) xm[i] = xm[i-1];
      xm[0] = x;
      acc = 0;
      for (int i = 0; i < 4; i++) acc += wm[i] * xm[i];
      ex.y = sat8(acc >>> 6);
      ex.e = sat8(d - ex.y);
      if (!frz)
         for (int i = 0; i < 4; i++) wm[i] = sat8(wm[i] + ((ex.e * xm[i]) >>> 8));
      ex.lat = frz ? 6 : 10;
      sbQ.push_back(ex);
   endfunction

   // Filter output the model would give for a new sample x, without accepting it.
   function automatic int predictY(input int x);
      int acc;
      acc = wm[0] * x;
      for (int i = 1; i < 4; i++) acc += wm[i] * xm[i-1];
      return sat8(acc >>> 6);
   endfunction

   function automatic int weightSum();
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) s += wm[i];
      return s;
   endfunction

   // Offers one sample, then while the iteration runs keeps junk on in_valid
   // and out_ready high (both must be ignored) and flips freeze. When out_valid
   // rises the result is checked, held for holdCycles, then consumed.
   task automatic applyStimulus(input int x, input int d, input bit frz, input int holdCycles,
                                output int yObs, output int eObs);
      int   waitCnt;
      int   lat;
      exp_t ex;
      @(negedge clk);
      waitCnt = 0;
      while (!in_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!in_ready) checkOutput("acceptTimeout", 0, 1);
      in_valid  = 1'b1;
      x_in      = 8'(x);
      d_in      = 8'(d);
      freeze    = frz;
      out_ready = 1'b0;
      modelAccept(x, d, frz);
      @(posedge clk);
      #1;
      x_in      = -8'sd5;
      d_in      = 8'sd99;
      freeze    = !frz;
      out_ready = 1'b1;
      checkOutput("busyAfterAccept", int'(busy), 1);
      checkOutput("inReadyWhileBusy", int'(in_ready), 0);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ex = sbQ.pop_front();
      checkOutput("outValidSeen", int'(out_valid), 1);
      checkOutput("latency", lat, ex.lat);
      checkOutput("yOut", int'(y_out), ex.y);
      checkOutput("eOut", int'(e_out), ex.e);
      yObs = int'(y_out);
      eObs = int'(e_out);
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk);
         #1;
         checkOutput("outValidHold", int'(out_valid), 1);
         checkOutput("yHold", int'(y_out), ex.y);
         checkOutput("eHold", int'(e_out), ex.e);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("outValidDrop", int'(out_valid), 0);
      checkOutput("backToIdle", int'(in_ready), 1);
   endtask

   initial begin
      int yObs, eObs, sumBefore, dFloor, seen;
      rst       = 1'b0;
      in_valid  = 1'b0;
      x_in      = '0;
      d_in      = '0;
      freeze    = 1'b0;
      out_ready = 1'b0;
      modelReset();

      // Reset held for three edges, then released.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstInReady", int'(in_ready), 1);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstOutValid", int'(out_valid), 0);
      checkOutput("rstY", int'(y_out), 0);
      checkOutput("rstE", int'(e_out), 0);

      // First two samples from zero weights: (0,32) then (8,24).
      applyStimulus(64, 32, 1'b0, 0, yObs, eObs);
      applyStimulus(64, 32, 1'b0, 0, yObs, eObs);
      checkOutput("secondY", yObs, 8);
      checkOutput("secondE", eObs, 24);

      // Frozen iteration under five cycles of backpressure; a second frozen
      // sample shows the weights were left alone.
      applyStimulus(64, 32, 1'b1, 5, yObs, eObs);
      applyStimulus(64, 32, 1'b1, 0, yObs, eObs);

      // Train towards y=127, then a large sample saturates y and e.
      for (int i = 0; i < 12; i++) applyStimulus(64, 127, 1'b0, 0, yObs, eObs);
      applyStimulus(127, -128, 1'b1, 0, yObs, eObs);
      checkOutput("satY", yObs, 127);
      checkOutput("satE", eObs, -128);

      // Floor rounding: an error of -1 against x=1 must still take 1 off each weight.
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1'b1, 0, yObs, eObs);
      sumBefore = weightSum();
      dFloor    = predictY(1) - 1;
      applyStimulus(1, dFloor, 1'b0, 0, yObs, eObs);
      checkOutput("floorErr", eObs, -1);
      for (int i = 0; i < 4; i++) applyStimulus(64, 0, 1'b1, 0, yObs, eObs);
      checkOutput("floorDecrement", yObs, sumBefore - 4);

      // Reset during the second UPDATE cycle abandons the iteration.
      @(negedge clk);
      in_valid = 1'b1;
      x_in     = 8'sd64;
      d_in     = 8'sd32;
      freeze   = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midRstInReady", int'(in_ready), 1);
      checkOutput("midRstBusy", int'(busy), 0);
      checkOutput("midRstOutValid", int'(out_valid), 0);
      checkOutput("midRstY", int'(y_out), 0);
      checkOutput("midRstE", int'(e_out), 0);
      rst = 1'b1;
      modelReset();
      seen = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      checkOutput("noOutAfterRst", seen, 0);
      applyStimulus(64, 32, 1'b0, 0, yObs, eObs);
      checkOutput("postRstY", yObs, 0);
      checkOutput("postRstE", eObs, 32);
      applyStimulus(64, 32, 1'b0, 0, yObs, eObs);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lms_iter_ctrl.md
Name: lms_iter_ctrl

Overview:
Sequencer for one adaptive-filter (LMS) iteration around a single shared signed multiplier. For each accepted sample it performs three steps: a TAPS-cycle filter pass (y = sum w[k]*x[k]), an error computation (e = d - y), and a TAPS-cycle weight update, then presents y/e on an output handshake. It sits between the sample source and the error/monitor logic. It owns the tap delay line and the weight registers.

Parameters:
TAPS, 4, number of taps/weights (>=2)
DW, 8, signed width of samples, weights, y, e
FRAC, 6, fractional bits of weights; y = acc >>> FRAC
MU_SHIFT, 8, step size mu = 2^-MU_SHIFT; weight delta = (e*x[k]) >>> MU_SHIFT

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (asserted when 0)
in_valid  input  1  sample offered
in_ready  output  1  controller can accept sample (IDLE only)
x_in  input  DW  signed input sample
d_in  input  DW  signed desired response
freeze  input  1  when 1 at acceptance, this iteration skips the weight update
out_valid  output  1  y_out/e_out valid
out_ready  input  1  consumer accepts result
y_out  output  DW  signed filter output, saturated
e_out  output  DW  signed error d - y, saturated
busy  output  1  1 in any state except IDLE

Behaviour:
- Reset (rst==0 at an edge): state=IDLE; all x[k], w[k], acc, y_out, e_out = 0; out_valid=0; in_ready=1; busy=0. Reset takes priority in every state, including mid-FILTER/UPDATE. An in-flight iteration is discarded and weights return to 0.
- FSM states: IDLE, FILTER, ERROR, UPDATE, DONE.
- IDLE: in_ready=1. On in_valid: shift the delay line (x[0]<=x_in, x[k]<=x[k-1], x[TAPS-1] dropped), latch d_in and freeze, clear acc, set tap index k=0, go to FILTER.
- FILTER: one product per cycle: acc <= acc + w[k]*x[k], k increments. After TAPS cycles (k==TAPS-1 processed), go to ERROR.
- acc width: 2*DW + clog2(TAPS), full precision, no overflow.
- ERROR (1 cycle):
  - y = sat_DW(acc >>> FRAC), using arithmetic shift (floor).
  - e = sat_DW(d - y), computed at DW+1 bits before saturation.
  - Register y_out and e_out. k=0.
  - Go to UPDATE if the latched freeze==0, else go to DONE.
- UPDATE: one weight per cycle: w[k] <= sat_DW(w[k] + ((e*x[k]) >>> MU_SHIFT)). The product is 2*DW bits and the shift is floor. After TAPS cycles, go to DONE.
- sat_DW clamps to [-2^(DW-1), 2^(DW-1)-1].
- DONE: out_valid=1, with y_out/e_out held stable. On out_ready, out_valid drops next cycle and the FSM goes to IDLE. Without out_ready, it holds indefinitely.
- Latency: the accept edge is cycle 0. out_valid first rises after 2*TAPS+2 edges (TAPS+2 when frozen). Throughput: one sample per 2*TAPS+3 cycles minimum, because IDLE costs one cycle.
- in_valid outside IDLE is ignored (in_ready=0). The sample is not captured.
- out_ready outside DONE has no effect.
- freeze changes after acceptance have no effect on the current iteration.

Test Plan:
1. Reset: hold rst=0 for 3 cycles, then release -> in_ready=1, busy=0, out_valid=0, y_out=e_out=0, all weights 0.
2. First sample: x=64, d=32, freeze=0 -> out_valid exactly 10 cycles after accept (TAPS=4), with y_out=0 and e_out=32. Then w0=(32*64)>>>8=8 and w1..w3=0.
3. Second sample: x=64, d=32 -> acc=512, y_out=8, e_out=24. Then w0=14, w1=6, w2=w3=0.
4. Freeze and backpressure: freeze=1 with out_ready=0 for 5 cycles -> out_valid 6 cycles after accept, held with stable values; weights unchanged. Then out_ready=1 -> IDLE next cycle.
5. Floor and saturation:
   - Preload w0 via iterations so that y saturates to 127, then feed d=-128 -> e_out=-128 (saturated).
   - Feed e=-1 with x[k]=1 -> weight decrements by 1, confirming floor.
6. Reset mid-operation: assert rst=0 on the 2nd UPDATE cycle -> next edge gives IDLE, all weights 0, out_valid never asserted for that sample.
